psk_tx_scheduler: RTL and testbench

Frame-level scheduler for the PSK transmit path. It paces symbols at a fixed clock divisor and sequences each frame through three phases: a BPSK preamble, a BPSK or QPSK payload pulled from an upstream valid/ready stream, and a silent guard interval. It drives the symbol bits and the `is_bpsk` mode flag into the modulator and the signal-extension stage.

---
 rtl/psk_tx_pkg.sv | 14 +
 rtl/psk_sym_tick.sv | 27 ++
 rtl/psk_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_psk_tx_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_tx_pkg.sv
// Shared types and constants for the PSK transmit scheduler.
package psk_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_PAY,
        ST_GUARD
    } psk_state_t;

    localparam int unsigned SYM_W = 2;
    localparam logic [SYM_W-1:0] IDLE_SYM = 2'b00;

endpackage

// File: rtl/psk_sym_tick.sv
// Symbol-rate divider: counts 0..SYM_DIV-1 while enabled and flags the last cycle.
module psk_sym_tick #(
    parameter int unsigned SYM_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYM_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/psk_tx_scheduler.sv
// Frame scheduler: paced preamble, streamed payload and silent guard for the PSK modulator.
module psk_tx_scheduler
    import psk_tx_pkg::*;
#(
    parameter int unsigned SYM_DIV     = 8,
    parameter int unsigned PRE_LEN     = 32,
    parameter logic [31:0] PRE_PATTERN = 32'hF3A0_5C96,
    parameter int unsigned GUARD_LEN   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_qpsk,
    input  logic             s_valid,
    input  logic [SYM_W-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             sym_valid,
    output logic [SYM_W-1:0] sym_bits,
    output logic             is_bpsk,
    output logic             busy,
    output logic             underrun
);

    localparam int unsigned MAX_LEN = (PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN;
    localparam int unsigned IDX_W   = $clog2(MAX_LEN) + 1;
    localparam logic [IDX_W-1:0] PRE_LAST   = IDX_W'(PRE_LEN - 1);
    localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD_LEN - 1);
    // Preamble MSB parked at bit 31 so symbol idx is simply bit 31 after a left shift by idx.
    localparam logic [31:0] PAT_ALIGNED = PRE_PATTERN << (32 - PRE_LEN);

    psk_state_t       r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic             r_qpsk;
    logic             r_sym_valid, r_is_bpsk, r_underrun;
    logic [SYM_W-1:0] r_sym_bits;

    logic             w_busy, w_tick, w_accept;
    logic             w_emit, w_bpsk, w_underrun;
    logic [SYM_W-1:0] w_bits;
    logic [31:0]      w_pat_sh;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_pat_sh = PAT_ALIGNED << r_idx;

    psk_sym_tick #(
        .SYM_DIV(SYM_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (w_busy),
        .clr  (w_accept),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_accept   = 1'b0;
        w_emit     = 1'b0;
        w_bits     = IDLE_SYM;
        w_bpsk     = r_is_bpsk;
        w_underrun = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_PRE;
                    w_idx_nx   = '0;
                end
            end
            ST_PRE: begin
                if (w_tick) begin
                    w_emit = 1'b1;
                    w_bits = {1'b0, w_pat_sh[31]};
                    w_bpsk = 1'b1;
                    if (r_idx == PRE_LAST) begin
                        w_state_nx = ST_PAY;
                        w_idx_nx   = '0;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (w_tick) begin
                    w_emit = 1'b1;
                    w_bpsk = ~r_qpsk;
                    if (s_valid) begin
                        w_bits = r_qpsk ? s_data : {1'b0, s_data[0]};
                        if (s_last) begin
                            w_state_nx = ST_GUARD;
                            w_idx_nx   = '0;
                        end
                    end else begin
                        w_underrun = 1'b1;
                    end
                end
            end
            ST_GUARD: begin
                if (w_tick) begin
                    if (r_idx == GUARD_LAST) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_qpsk      <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_bits  <= IDLE_SYM;
            r_is_bpsk   <= 1'b1;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_idx       <= w_idx_nx;
            r_sym_valid <= w_emit;
            r_underrun  <= w_underrun;
            r_is_bpsk   <= w_bpsk;
            if (w_accept) begin
                r_qpsk <= cfg_qpsk;
            end
            if (w_emit) begin
                r_sym_bits <= w_bits;
            end
        end
    end

    assign s_ready   = w_tick && (r_state == ST_PAY);
    assign sym_valid = r_sym_valid;
    assign sym_bits  = r_sym_bits;
    assign is_bpsk   = r_is_bpsk;
    assign busy      = w_busy;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_psk_tx_scheduler.sv
// Randomized frame-level bench for psk_tx_scheduler against a symbol-list reference model.
module tb_psk_tx_scheduler;

    localparam int unsigned D   = 4;
    localparam int unsigned P   = 8;
    localparam int unsigned G   = 2;
    localparam logic [31:0] PAT = 32'h0000_00A5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cfg_qpsk = 1'b0;
    logic       s_valid = 1'b0;
    logic [1:0] s_data = 2'b00;
    logic       s_last = 1'b0;
    logic       s_ready, sym_valid, is_bpsk, busy, underrun;
    logic [1:0] sym_bits;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_bpsk = 1'b1;

    typedef struct packed {
        logic [1:0] bits;
        logic       bpsk;
        logic       und;
    } em_t;

    logic [1:0] pay_q[$];
    em_t        em_q[$];

    psk_tx_scheduler #(
        .SYM_DIV    (D),
        .PRE_LEN    (P),
        .PRE_PATTERN(PAT),
        .GUARD_LEN  (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_qpsk (cfg_qpsk),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .sym_valid(sym_valid),
        .sym_bits (sym_bits),
        .is_bpsk  (is_bpsk),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sym_valid"}, sym_valid, 0);
        chk({tag, "_sym_bits"}, sym_bits, 0);
        chk({tag, "_is_bpsk"}, is_bpsk, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start   = 1'b0;
            s_valid = 1'($urandom_range(0, 1));
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_sym_valid", sym_valid, 0);
            chk("idle_s_ready", s_ready, 0);
            chk("idle_is_bpsk", is_bpsk, exp_bpsk);
        end
    endtask

    // Expects start to have been driven at the preceding negedge; the next posedge is the accept edge.
    task automatic run_frame(input bit qpsk, input int drop_j, input bit probe_end,
                             input bit chain, input bit next_q);
        int np = pay_q.size();
        int nt = np + ((drop_j >= 0) ? 1 : 0);
        int tt = P + nt + G;
        int pi = 0;
        int pidx = 0;
        int busy_probe = int'($urandom_range(0, P * D - 2));
        int k, j;
        bit tick_now, exp_ready, ev;
        em_t e;
        logic [31:0] pat_v = PAT;

        em_q.delete();
        for (int i = 0; i < int'(P); i++)
            em_q.push_back('{bits: {1'b0, pat_v[P-1-i]}, bpsk: 1'b1, und: 1'b0});
        for (int jj = 0; jj < nt; jj++) begin
            if (jj == drop_j) begin
                em_q.push_back('{bits: 2'b00, bpsk: ~qpsk, und: 1'b1});
            end else begin
                em_q.push_back('{bits: qpsk ? pay_q[pi] : {1'b0, pay_q[pi][0]}, bpsk: ~qpsk, und: 1'b0});
                pi++;
            end
        end

        @(posedge clk);
        for (int rel = 0; rel <= tt * int'(D); rel++) begin
            @(negedge clk);
            k = rel / D;
            j = k - P;
            start    = 1'b0;
            cfg_qpsk = qpsk;
            if (rel == busy_probe) begin
                start    = 1'b1;
                cfg_qpsk = ~qpsk;
            end
            if (probe_end && rel == tt * int'(D) - 1) start = 1'b1;
            if (chain && rel == tt * int'(D)) begin
                start    = 1'b1;
                cfg_qpsk = next_q;
            end
            if (j >= 0 && j < nt && pidx < np) begin
                s_valid = (j != drop_j);
                s_data  = pay_q[pidx];
                s_last  = (pidx == np - 1);
            end else begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 2'($urandom);
                s_last  = 1'($urandom_range(0, 1));
            end
            #1;
            tick_now  = (rel < tt * int'(D)) && (rel % D == D - 1);
            exp_ready = tick_now && j >= 0 && j < nt;
            ev        = (rel >= int'(D)) && (rel % D == 0) && (rel / D - 1 < int'(P) + nt);
            chk("busy", busy, rel < tt * int'(D));
            chk("s_ready", s_ready, exp_ready);
            chk("sym_valid", sym_valid, ev);
            if (ev) begin
                e        = em_q[rel / D - 1];
                exp_bpsk = e.bpsk;
                chk("sym_bits", sym_bits, e.bits);
                chk("underrun", underrun, e.und);
            end else begin
                chk("underrun_idle", underrun, 0);
            end
            chk("is_bpsk", is_bpsk, exp_bpsk);
            if (s_ready && s_valid) pidx++;
        end
    endtask

    initial begin
        bit q, nq, chain, launched;
        int np, drop;

        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // BPSK frame, upper data bit must be masked off
        pay_q = '{2'b11, 2'b10, 2'b11};
        @(negedge clk);
        start = 1'b1;
        cfg_qpsk = 1'b0;
        run_frame(1'b0, -1, 1'b0, 1'b0, 1'b0);
        idle_cycles(3);

        // QPSK frame; start in the GUARD->IDLE cycle then again one cycle later
        pay_q = '{2'b11, 2'b01};
        @(negedge clk);
        start = 1'b1;
        cfg_qpsk = 1'b1;
        run_frame(1'b1, -1, 1'b1, 1'b1, 1'b0);

        // Chained BPSK frame with one underrun mid-payload
        pay_q = '{2'b01, 2'b00, 2'b01, 2'b11};
        run_frame(1'b0, 2, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);

        q = 1'($urandom_range(0, 1));
        launched = 1'b0;
        for (int f = 0; f < 10; f++) begin
            np = int'($urandom_range(1, 5));
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, np - 1)) : -1;
            pay_q.delete();
            for (int i = 0; i < np; i++) pay_q.push_back(2'($urandom));
            if (!launched) begin
                idle_cycles(int'($urandom_range(1, 4)));
                @(negedge clk);
                start = 1'b1;
                cfg_qpsk = q;
            end
            chain = (f < 9) && ($urandom_range(0, 1) == 1);
            nq = 1'($urandom_range(0, 1));
            run_frame(q, drop, 1'($urandom_range(0, 1)), chain, nq);
            launched = chain;
            q = nq;
        end
        idle_cycles(2);

        // Reset during the QPSK payload
        @(negedge clk);
        start = 1'b1;
        cfg_qpsk = 1'b1;
        s_valid = 1'b1;
        s_data = 2'b10;
        s_last = 1'b0;
        for (int i = 0; i < int'((P + 1) * D + 2); i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("pre_reset_is_bpsk", is_bpsk, 0);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("midframe_reset");
        rst_n = 1'b1;
        exp_bpsk = 1'b1;
        for (int i = 0; i < int'(3 * D); i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            #1;
            chk("post_reset_s_ready", s_ready, 0);
            chk("post_reset_busy", busy, 0);
            chk("post_reset_sym_valid", sym_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
